// File: rtl/cnt_job_sched_pkg.sv
// Shared types for the counter job scheduler.
package cnt_job_sched_pkg;

    // Job lifecycle: wait for a request, count, then report completion.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_job_sched_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at the requester after
// last_grant and wraps, so the most recently served requester goes last.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    // First requester found scanning upward from last_grant+1 wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_job_sched.sv
// Round-robin job scheduler around one shared loadable up-counter. A job loads
// the requester's start value, counts up to TERMINAL, then pulses done with the
// requester's id.
//
// Handshake: req_valid[i] is raised by requester i and held, with a stable
// req_start slice, until the cycle where req_valid[i] & req_ready[i] is high at
// a rising clk edge; that edge is the transfer. req_ready is one-hot, only ever
// asserted in IDLE, and is computed combinationally from req_valid.
module cnt_job_sched
    import cnt_job_sched_pkg::*;
#(
    parameter int               NUM_REQ  = 4,
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = 4'hF,
    localparam int              ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_start,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     abort,
    output logic                     busy,
    output logic [ID_W-1:0]          active_id,
    output logic [WIDTH-1:0]         count,
    output logic                     done,
    output logic [ID_W-1:0]          done_id
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [ID_W-1:0]  active_id_q, active_id_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic [WIDTH-1:0] sel_start;
    logic             accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .enable     (state_q == S_IDLE),
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    // Start value of the granted requester (grant is one-hot or zero).
    always_comb begin
        sel_start = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_start = req_start[i*WIDTH +: WIDTH];
        end
    end

    // Next state and datapath: load on accept, count in RUN, hold otherwise.
    // abort is checked before the terminal compare so it always wins.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        active_id_d  = active_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    count_d      = sel_start;
                    active_id_d  = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (count_q == TERMINAL) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; the pointer resets to the last requester
    // so requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            active_id_q  <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            active_id_q  <= active_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Status outputs; an abort during DONE swallows the done pulse.
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign active_id = active_id_q;
    assign count     = count_q;
    assign done      = (state_q == S_DONE) && !abort;
    assign done_id   = done ? active_id_q : '0;

endmodule

// File: tb/tb_cnt_job_sched.sv
// Bench for cnt_job_sched: directed table, hand-written corner sequences and a
// randomized run checked against a job-level reference model.
module tb_cnt_job_sched;

    localparam int         NUM_REQ = 4;
    localparam int         WIDTH   = 4;
    localparam int         ID_W    = 2;
    localparam logic [3:0] TERM    = 4'hF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT (TERMINAL = F)
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_start;
    logic        abort, busy, done;
    logic [1:0]  active_id, done_id;
    logic [3:0]  count;

    // second DUT (TERMINAL = 3) for the wrap path
    logic [3:0]  r3_valid, r3_ready;
    logic [15:0] r3_start;
    logic        r3_abort, r3_busy, r3_done;
    logic [1:0]  r3_active_id, r3_done_id;
    logic [3:0]  r3_count;

    cnt_job_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TERMINAL(4'hF)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_start(req_start),
        .req_ready(req_ready), .abort(abort), .busy(busy), .active_id(active_id),
        .count(count), .done(done), .done_id(done_id)
    );

    cnt_job_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TERMINAL(4'h3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(r3_valid), .req_start(r3_start),
        .req_ready(r3_ready), .abort(r3_abort), .busy(r3_busy), .active_id(r3_active_id),
        .count(r3_count), .done(r3_done), .done_id(r3_done_id)
    );

    // ---------------- scoreboard / counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [ID_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (job level) ----------------
    // A job of start s runs len = ((TERM-s) mod 16)+1 cycles showing s, s+1, ...
    // then one done cycle; m_age counts cycles since the accept.
    bit         m_busy;
    int         m_age, m_len, m_last, m_id;
    logic [3:0] m_start, m_count;
    logic [3:0] e_ready, e_count;
    logic       e_busy, e_done;
    logic [1:0] e_active, e_done_id;

    logic [3:0]  pend;
    logic [15:0] pend_start;
    logic [3:0]  wrap_seq[6] = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};

    function automatic void model_reset();
        m_busy = 1'b0; m_age = 0; m_len = 0; m_last = NUM_REQ - 1;
        m_id = 0; m_start = '0; m_count = '0;
    endfunction

    function automatic void model_expect(input logic [3:0] v, input logic a);
        int idx;
        e_ready = '0;
        if (!m_busy) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_last + k) % NUM_REQ;
                if (v[idx] && e_ready == 4'b0) e_ready[idx] = 1'b1;
            end
        end
        e_busy    = m_busy;
        e_active  = 2'(m_id);
        e_count   = m_busy ? 4'(int'(m_start) + ((m_age < m_len) ? m_age : m_len) - 1) : m_count;
        e_done    = m_busy && (m_age == m_len + 1) && !a;
        e_done_id = e_done ? 2'(m_id) : 2'd0;
    endfunction

    function automatic void model_advance(input logic [3:0] v, input logic [15:0] s, input logic a);
        int g;
        g = 0;
        if (!m_busy) begin
            if ((e_ready & v) != 4'b0) begin
                for (int i = 0; i < NUM_REQ; i++) if (e_ready[i]) g = i;
                m_busy  = 1'b1;
                m_age   = 1;
                m_start = s[g*4 +: 4];
                m_len   = int'(4'(TERM - m_start)) + 1;
                m_id    = g;
                m_last  = g;
            end
        end else if (a || m_age == m_len + 1) begin
            m_busy  = 1'b0;
            m_count = e_count;
        end else begin
            m_age++;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1: apply inputs, settle, compare against the model.
    task automatic drive_check(input logic [3:0] v, input logic [15:0] s, input logic a);
        req_valid = v; req_start = s; abort = a;
        #1;
        model_expect(v, a);
        chk("ready", req_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("count", count, e_count);
        chk("active_id", active_id, e_active);
        chk("done", done, e_done);
        chk("done_id", done_id, e_done_id);
        if (e_done) exp_q.push_back(e_done_id);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL done_sb: got done id %0h expected no done", done_id);
            end else begin
                chk("done_sb", done_id, exp_q.pop_front());
            end
        end
    endtask

    task automatic tick(input logic [3:0] v, input logic [15:0] s, input logic a);
        @(posedge clk); #1;
        model_advance(v, s, a);
    endtask

    task automatic post(input int id, input logic [3:0] st);
        pend[id] = 1'b1;
        pend_start[id*4 +: 4] = st;
    endtask

    task automatic step_drive(input logic a);
        drive_check(pend, pend_start, a);
    endtask

    // Accepted requesters drop their valid after the transfer edge.
    task automatic step_tick(input logic a);
        tick(pend, pend_start, a);
        pend = pend & ~e_ready;
    endtask

    task automatic step(input logic a);
        step_drive(a);
        step_tick(a);
    endtask

    task automatic wait_done(input string name, input logic [1:0] exp_id);
        logic seen;
        logic [1:0] id;
        seen = 1'b0; id = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step_drive(1'b0);
            if (done === 1'b1) begin seen = 1'b1; id = done_id; end
            step_tick(1'b0);
        end
        chk({name, "_seen"}, seen, 1'b1);
        chk({name, "_id"}, id, exp_id);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0; req_start = '0; abort = 1'b0;
        r3_valid = '0; r3_start = '0; r3_abort = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 4'h0);
        chk("rst_active_id", active_id, 2'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_id", done_id, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        pend = '0; pend_start = '0;
        exp_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  v;
        logic [15:0] s;
        logic        a;
        logic [3:0]  rdy;
        logic        bsy;
        logic [3:0]  cnt;
        logic        dn;
        logic [1:0]  did;
        logic [1:0]  aid;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pend = '0; pend_start = '0;
        do_reset();

        // Job from req0, start C: counts C..F then done at t+5, idle at t+6.
        tbl[0] = '{4'b0001, 16'h000C, 1'b0, 4'b0001, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0};
        tbl[1] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b1, 4'hC, 1'b0, 2'd0, 2'd0};
        tbl[2] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b1, 4'hD, 1'b0, 2'd0, 2'd0};
        tbl[3] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b1, 4'hE, 1'b0, 2'd0, 2'd0};
        tbl[4] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b1, 4'hF, 1'b0, 2'd0, 2'd0};
        tbl[5] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b1, 4'hF, 1'b1, 2'd0, 2'd0};
        tbl[6] = '{4'b0000, 16'h000C, 1'b0, 4'b0000, 1'b0, 4'hF, 1'b0, 2'd0, 2'd0};
        for (int i = 0; i < 7; i++) begin
            drive_check(tbl[i].v, tbl[i].s, tbl[i].a);
            chk("tbl_ready", req_ready, tbl[i].rdy);
            chk("tbl_busy", busy, tbl[i].bsy);
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_done", done, tbl[i].dn);
            chk("tbl_done_id", done_id, tbl[i].did);
            chk("tbl_active_id", active_id, tbl[i].aid);
            tick(tbl[i].v, tbl[i].s, tbl[i].a);
        end

        // Round-robin order: req0 before req2 from reset, then req3 before req0.
        do_reset();
        post(0, 4'hE); post(2, 4'hD);
        step_drive(1'b0); chk("rr_first_req0", req_ready, 4'b0001); step_tick(1'b0);
        wait_done("rr_job0", 2'd0);
        step_drive(1'b0); chk("rr_then_req2", req_ready, 4'b0100); step_tick(1'b0);
        post(3, 4'hF); post(0, 4'h1);
        wait_done("rr_job2", 2'd2);
        step_drive(1'b0); chk("rr_req3_first", req_ready, 4'b1000); step_tick(1'b0);
        // start == TERMINAL: one RUN cycle, done at t+2
        step_drive(1'b0); chk("term_start_count", count, 4'hF); chk("term_start_nodone", done, 1'b0); step_tick(1'b0);
        step_drive(1'b0); chk("term_start_done", done, 1'b1); chk("term_start_id", done_id, 2'd3); step_tick(1'b0);
        step_drive(1'b0); chk("rr_req0_last", req_ready, 4'b0001); step_tick(1'b0);
        wait_done("rr_job0b", 2'd0);

        // Wrap path on the TERMINAL=3 instance: E,F,0,1,2,3 then done.
        r3_valid = 4'b0001; r3_start = 16'h000E;
        step_drive(1'b0); chk("wrap_ready", r3_ready, 4'b0001); step_tick(1'b0);
        r3_valid = '0;
        for (int k = 0; k < 6; k++) begin
            step_drive(1'b0);
            chk("wrap_count", r3_count, wrap_seq[k]);
            chk("wrap_nodone", r3_done, 1'b0);
            step_tick(1'b0);
        end
        step_drive(1'b0); chk("wrap_done", r3_done, 1'b1); chk("wrap_done_count", r3_count, 4'h3); step_tick(1'b0);
        step_drive(1'b0); chk("wrap_idle", r3_busy, 1'b0); step_tick(1'b0);

        // Abort at count 5 of a start=2 job; pending req1 accepted right after.
        post(0, 4'h2);
        step(1'b0);
        post(1, 4'h7);
        for (int k = 0; k < 3; k++) step(1'b0);
        step_drive(1'b1); chk("abort_at_count", count, 4'h5); chk("abort_nodone", done, 1'b0); step_tick(1'b1);
        step_drive(1'b0);
        chk("abort_idle", busy, 1'b0); chk("abort_no_pulse", done, 1'b0);
        chk("abort_hold", count, 4'h5); chk("abort_next_grant", req_ready, 4'b0010);
        step_tick(1'b0);
        step_drive(1'b0); chk("abort_next_busy", busy, 1'b1); chk("abort_next_id", active_id, 2'd1);
        chk("abort_next_count", count, 4'h7); step_tick(1'b0);
        wait_done("abort_job1", 2'd1);

        // Asynchronous reset in the middle of a job.
        post(2, 4'h3);
        step(1'b0); step(1'b0); step(1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_count", count, 4'h0);
        chk("arst_active_id", active_id, 2'd0);
        chk("arst_done", done, 1'b0);
        req_valid = '0; pend = '0;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        exp_q.delete();
        post(1, 4'hA);
        step_drive(1'b0); chk("arst_fresh_grant", req_ready, 4'b0010); step_tick(1'b0);
        step_drive(1'b0); chk("arst_fresh_count", count, 4'hA); chk("arst_fresh_id", active_id, 2'd1); step_tick(1'b0);
        wait_done("arst_job1", 2'd1);

        // Randomized traffic with occasional aborts.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) post(i, 4'($urandom_range(0, 15)));
            end
            step($urandom_range(0, 15) == 0);
        end

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
